// File: rtl/ama_riscv_defines.sv
// ---------------------------------------------------------------------------
// ama_riscv_defines
// Shared type definitions for the memory-side arbitration logic.
//   arb_state_e : arbiter FSM states
//   arb_owner_e : which cache owns the outstanding memory transaction
// ---------------------------------------------------------------------------
package ama_riscv_defines;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_IC = 1'b0,
      ARB_DC = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/ama_riscv_rr_arb2.sv
// ---------------------------------------------------------------------------
// ama_riscv_rr_arb2
// Two-way round-robin picker, purely combinational.
// Ports:
//   req   [1:0]  request vector, bit 0 = icache, bit 1 = dcache
//   last         requester granted most recently (0 = icache, 1 = dcache)
//   grant [1:0]  one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module ama_riscv_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // tie: the side that did not win last time goes first
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// ---------------------------------------------------------------------------
// ama_riscv_mem_arb
// Shares one backing-memory port between the icache and dcache. One memory
// transaction is outstanding at a time; round-robin on simultaneous requests.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no transaction; picker result drives the req_ready of winner
// ARB_ISSUE | registered request presented on mem_req_* until accepted
// ARB_WAIT  | read accepted by memory, waiting for mem_rsp_valid
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   ic_req_* / ic_rsp_*       icache line-fill request / response
//   dc_req_* / dc_rsp_*       dcache fill or write-back request / response
//   mem_req_* / mem_rsp_*     backing memory request / read response
//   conflict_cnt              cycles spent in ARB_IDLE with both requesting
// ---------------------------------------------------------------------------
module ama_riscv_mem_arb
   import ama_riscv_defines::*;
#(
   parameter int MEM_ADDR_W = 14,
   parameter int LINE_W     = 128
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  ic_req_valid,
   output logic                  ic_req_ready,
   input  logic [MEM_ADDR_W-1:0] ic_req_addr,
   output logic                  ic_rsp_valid,
   output logic [LINE_W-1:0]     ic_rsp_data,

   input  logic                  dc_req_valid,
   output logic                  dc_req_ready,
   input  logic [MEM_ADDR_W-1:0] dc_req_addr,
   input  logic                  dc_req_we,
   input  logic [LINE_W-1:0]     dc_req_wdata,
   output logic                  dc_rsp_valid,
   output logic [LINE_W-1:0]     dc_rsp_data,

   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [MEM_ADDR_W-1:0] mem_req_addr,
   output logic                  mem_req_we,
   output logic [LINE_W-1:0]     mem_req_wdata,
   input  logic                  mem_rsp_valid,
   input  logic [LINE_W-1:0]     mem_rsp_data,

   output logic [31:0]           conflict_cnt
);

   arb_state_e            state_q;
   arb_owner_e            owner_q;
   arb_owner_e            last_grant_q;
   logic [MEM_ADDR_W-1:0] addr_q;
   logic                  we_q;
   logic [LINE_W-1:0]     wdata_q;
   logic                  ic_rsp_valid_q;
   logic                  dc_rsp_valid_q;
   logic [LINE_W-1:0]     ic_rsp_data_q;
   logic [LINE_W-1:0]     dc_rsp_data_q;
   logic [31:0]           conflict_cnt_q;

   logic [1:0]            grant;
   logic                  hs_ic;
   logic                  hs_dc;

   ama_riscv_rr_arb2 u_rr_arb2 (
      .req   ({dc_req_valid, ic_req_valid}),
      .last  (last_grant_q == ARB_DC),
      .grant (grant)
   );

   // Readies are combinational so a lone requester is accepted the same
   // cycle it raises valid; dropping valid simply removes it from the picker.
   always_comb begin
      ic_req_ready = (state_q == ARB_IDLE) && grant[0];
      dc_req_ready = (state_q == ARB_IDLE) && grant[1];
   end

   assign hs_ic = ic_req_valid && ic_req_ready;
   assign hs_dc = dc_req_valid && dc_req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ARB_IDLE;
         owner_q        <= ARB_IC;
         last_grant_q   <= ARB_DC;
         addr_q         <= '0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         ic_rsp_valid_q <= 1'b0;
         dc_rsp_valid_q <= 1'b0;
         ic_rsp_data_q  <= '0;
         dc_rsp_data_q  <= '0;
         conflict_cnt_q <= '0;
      end else begin
         ic_rsp_valid_q <= 1'b0;
         dc_rsp_valid_q <= 1'b0;

         if ((state_q == ARB_IDLE) && ic_req_valid && dc_req_valid)
            conflict_cnt_q <= conflict_cnt_q + 32'd1;

         case (state_q)
            ARB_IDLE: begin
               if (hs_ic) begin
                  owner_q      <= ARB_IC;
                  last_grant_q <= ARB_IC;
                  addr_q       <= ic_req_addr;
                  we_q         <= 1'b0;
                  wdata_q      <= '0;
                  state_q      <= ARB_ISSUE;
               end else if (hs_dc) begin
                  owner_q      <= ARB_DC;
                  last_grant_q <= ARB_DC;
                  addr_q       <= dc_req_addr;
                  we_q         <= dc_req_we;
                  wdata_q      <= dc_req_wdata;
                  state_q      <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               // write-backs complete on acceptance; reads wait for data
               if (mem_req_ready)
                  state_q <= we_q ? ARB_IDLE : ARB_WAIT;
            end
            ARB_WAIT: begin
               if (mem_rsp_valid) begin
                  if (owner_q == ARB_IC) begin
                     ic_rsp_data_q  <= mem_rsp_data;
                     ic_rsp_valid_q <= 1'b1;
                  end else begin
                     dc_rsp_data_q  <= mem_rsp_data;
                     dc_rsp_valid_q <= 1'b1;
                  end
                  state_q <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign mem_req_valid = (state_q == ARB_ISSUE);
   assign mem_req_addr  = addr_q;
   assign mem_req_we    = we_q;
   assign mem_req_wdata = wdata_q;
   assign ic_rsp_valid  = ic_rsp_valid_q;
   assign ic_rsp_data   = ic_rsp_data_q;
   assign dc_rsp_valid  = dc_rsp_valid_q;
   assign dc_rsp_data   = dc_rsp_data_q;
   assign conflict_cnt  = conflict_cnt_q;

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
module tb_ama_riscv_mem_arb;

   localparam int AW = 14;
   localparam int LW = 128;

   logic          clk;
   logic          rst;
   logic          ic_req_valid, ic_req_ready, ic_rsp_valid;
   logic [AW-1:0] ic_req_addr;
   logic [LW-1:0] ic_rsp_data;
   logic          dc_req_valid, dc_req_ready, dc_req_we, dc_rsp_valid;
   logic [AW-1:0] dc_req_addr;
   logic [LW-1:0] dc_req_wdata, dc_rsp_data;
   logic          mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
   logic [AW-1:0] mem_req_addr;
   logic [LW-1:0] mem_req_wdata, mem_rsp_data;
   logic [31:0]   conflict_cnt;

   int n_asrt = 0;
   int n_fail = 0;

   ama_riscv_mem_arb #(.MEM_ADDR_W(AW), .LINE_W(LW)) dut (
      .clk           (clk),
      .rst           (rst),
      .ic_req_valid  (ic_req_valid),
      .ic_req_ready  (ic_req_ready),
      .ic_req_addr   (ic_req_addr),
      .ic_rsp_valid  (ic_rsp_valid),
      .ic_rsp_data   (ic_rsp_data),
      .dc_req_valid  (dc_req_valid),
      .dc_req_ready  (dc_req_ready),
      .dc_req_addr   (dc_req_addr),
      .dc_req_we     (dc_req_we),
      .dc_req_wdata  (dc_req_wdata),
      .dc_rsp_valid  (dc_rsp_valid),
      .dc_rsp_data   (dc_rsp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_we    (mem_req_we),
      .mem_req_wdata (mem_req_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .conflict_cnt  (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level reference: at most one outstanding transaction,
   // tracked as "pending at memory" (not yet accepted) or "awaiting data".
   bit            m_busy, m_sent, m_owner, m_we, m_last, exp_ic_v, exp_dc_v;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_wdata, m_ic_data, m_dc_data;
   logic [31:0]   m_cnt;

   task automatic m_reset();
      m_busy = 0; m_sent = 0; m_owner = 0; m_we = 0; m_last = 1;
      exp_ic_v = 0; exp_dc_v = 0;
      m_addr = '0; m_wdata = '0; m_ic_data = '0; m_dc_data = '0; m_cnt = '0;
   endtask

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp_v);
      n_asrt++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic set_in(input bit icv, input logic [AW-1:0] ica, input bit dcv,
                         input logic [AW-1:0] dca, input bit dwe, input logic [LW-1:0] dwd,
                         input bit mrdy, input bit mrv, input logic [LW-1:0] mrd);
      ic_req_valid = icv; ic_req_addr = ica;
      dc_req_valid = dcv; dc_req_addr = dca; dc_req_we = dwe; dc_req_wdata = dwd;
      mem_req_ready = mrdy; mem_rsp_valid = mrv; mem_rsp_data = mrd;
   endtask

   // Called just after a falling edge with inputs applied; checks the current
   // cycle, advances one clock, then checks the registered results.
   task automatic cycle();
      logic [1:0] win;
      win = 2'b00;
      #1;
      if (!m_busy) begin
         if (ic_req_valid && dc_req_valid) win = m_last ? 2'b01 : 2'b10;
         else                              win = {dc_req_valid, ic_req_valid};
      end
      chk("ic_req_ready", ic_req_ready, win[0]);
      chk("dc_req_ready", dc_req_ready, win[1]);
      chk("mem_req_valid", mem_req_valid, m_busy && !m_sent);
      if (m_busy && !m_sent) begin
         chk("mem_req_addr", mem_req_addr, m_addr);
         chk("mem_req_we", mem_req_we, m_we);
         if (m_we) chk("mem_req_wdata", mem_req_wdata, m_wdata);
      end
      @(posedge clk);
      exp_ic_v = 0; exp_dc_v = 0;
      if (!m_busy) begin
         if (ic_req_valid && dc_req_valid) m_cnt = m_cnt + 32'd1;
         if (win[0]) begin
            m_busy = 1; m_sent = 0; m_owner = 0; m_last = 0;
            m_addr = ic_req_addr; m_we = 0;
         end else if (win[1]) begin
            m_busy = 1; m_sent = 0; m_owner = 1; m_last = 1;
            m_addr = dc_req_addr; m_we = dc_req_we; m_wdata = dc_req_wdata;
         end
      end else if (!m_sent) begin
         if (mem_req_ready) begin
            if (m_we) m_busy = 0;
            else      m_sent = 1;
         end
      end else if (mem_rsp_valid) begin
         m_busy = 0;
         if (m_owner == 0) begin m_ic_data = mem_rsp_data; exp_ic_v = 1; end
         else              begin m_dc_data = mem_rsp_data; exp_dc_v = 1; end
      end
      @(negedge clk);
      chk("ic_rsp_valid", ic_rsp_valid, exp_ic_v);
      chk("dc_rsp_valid", dc_rsp_valid, exp_dc_v);
      chk("ic_rsp_data", ic_rsp_data, m_ic_data);
      chk("dc_rsp_data", dc_rsp_data, m_dc_data);
      chk("conflict_cnt", conflict_cnt, m_cnt);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(0, '0, 0, '0, 0, '0, 0, 0, '0);
      m_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   logic [LW-1:0] beef, ones, rnd;

   initial begin
      beef = {4{32'hDEAD_BEEF}};
      ones = '1;
      do_reset();

      // reset state
      #1;
      chk("rst_ic_ready", ic_req_ready, 0);
      chk("rst_dc_ready", dc_req_ready, 0);
      chk("rst_mem_valid", mem_req_valid, 0);
      chk("rst_ic_rsp", {ic_rsp_valid, ic_rsp_data}, '0);
      chk("rst_dc_rsp", {dc_rsp_valid, dc_rsp_data}, '0);
      chk("rst_cnt", conflict_cnt, 0);
      @(negedge clk);

      // lone icache read at 0x010
      set_in(1, 14'h010, 0, '0, 0, '0, 0, 0, '0);
      #1 chk("s1_ic_ready_same_cycle", ic_req_ready, 1);
      cycle();
      set_in(0, '0, 0, '0, 0, '0, 1, 0, '0);
      #1 chk("s1_mem_valid", mem_req_valid, 1);
      chk("s1_mem_addr", mem_req_addr, 14'h010);
      chk("s1_mem_we", mem_req_we, 0);
      cycle();
      set_in(0, '0, 0, '0, 0, '0, 0, 1, beef);
      cycle();
      chk("s1_ic_rsp_data", ic_rsp_data, beef);
      chk("s1_ic_rsp_valid", ic_rsp_valid, 1);
      set_in(0, '0, 0, '0, 0, '0, 0, 0, '0);
      cycle();
      chk("s1_rsp_hold", ic_rsp_data, beef);

      // spurious responses in IDLE and ISSUE
      set_in(0, '0, 0, '0, 0, '0, 0, 1, ~beef);
      cycle();
      set_in(1, 14'h123, 0, '0, 0, '0, 0, 0, '0);
      cycle();
      set_in(0, '0, 0, '0, 0, '0, 0, 1, ~beef);
      cycle();
      chk("s4_still_issuing", mem_req_valid, 1);
      set_in(0, '0, 0, '0, 0, '0, 1, 0, '0);
      cycle();
      set_in(0, '0, 0, '0, 0, '0, 0, 1, {4{32'h1234_5678}});
      cycle();

      // reset while a read waits for data
      set_in(1, 14'h055, 0, '0, 0, '0, 0, 0, '0);
      cycle();
      set_in(0, '0, 0, '0, 0, '0, 1, 0, '0);
      cycle();
      set_in(0, '0, 0, '0, 0, '0, 0, 0, '0);
      rst = 1'b1;
      #1;
      chk("s5_rst_mem_valid", mem_req_valid, 0);
      chk("s5_rst_ic_data", ic_rsp_data, '0);
      chk("s5_rst_ready", {ic_req_ready, dc_req_ready}, 0);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      set_in(0, '0, 0, '0, 0, '0, 0, 1, beef);
      cycle();
      chk("s5_no_late_rsp", ic_rsp_valid, 0);

      // three back-to-back ties from reset: IC, DC, IC
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_in(1, 14'h020 + 14'(k), 1, 14'h200 + 14'(k), 0, '0, 0, 0, '0);
         #1 chk("s2_grant_ic", ic_req_ready, (k % 2) == 0);
         chk("s2_grant_dc", dc_req_ready, (k % 2) == 1);
         cycle();
         set_in(0, '0, 0, '0, 0, '0, 1, 0, '0);
         cycle();
         set_in(0, '0, 0, '0, 0, '0, 0, 1, {4{$urandom}});
         cycle();
      end
      chk("s2_conflict_cnt", conflict_cnt, 3);

      // dcache write-back with memory stalling 5 cycles
      set_in(0, '0, 1, 14'h3FFF, 1, ones, 0, 0, '0);
      cycle();
      set_in(0, '0, 0, '0, 0, '0, 0, 0, '0);
      repeat (5) cycle();
      set_in(0, '0, 0, '0, 0, '0, 1, 0, '0);
      #1 chk("s3_addr", mem_req_addr, 14'h3FFF);
      chk("s3_wdata", mem_req_wdata, ones);
      cycle();
      set_in(0, '0, 0, '0, 0, '0, 0, 0, '0);
      cycle();
      chk("s3_no_rsp", {ic_rsp_valid, dc_rsp_valid}, 0);

      // conflict counter wrap
      force dut.conflict_cnt_q = 32'hFFFF_FFFF;
      set_in(1, 14'h001, 1, 14'h002, 0, '0, 0, 0, '0);
      #1 release dut.conflict_cnt_q;
      m_cnt = 32'hFFFF_FFFF;
      cycle();
      chk("s6_wrap", conflict_cnt, 0);
      set_in(0, '0, 0, '0, 0, '0, 1, 0, '0);
      cycle();
      set_in(0, '0, 0, '0, 0, '0, 0, 1, beef);
      cycle();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         set_in(1'($urandom_range(0, 1)), 14'($urandom), 1'($urandom_range(0, 1)),
                14'($urandom), 1'($urandom_range(0, 1)), ~rnd,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0), rnd);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/ama_riscv_mem_arb.md
AMA_RISCV_MEM_ARB -- requirements
Module: ama_riscv_mem_arb

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_W, default 14, meaning the line address width (128-bit lines).
REQ-002 The block SHALL have parameter LINE_W, default 128, meaning the cache line width in bits.
REQ-003 The block SHALL have these clock and reset ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
REQ-004 The block SHALL have these icache ports:
- ic_req_valid  in  1  icache line-fill request
- ic_req_ready  out  1  request accepted this cycle
- ic_req_addr  in  MEM_ADDR_W  line address
- ic_rsp_valid  out  1  fill data valid, one-cycle pulse
- ic_rsp_data  out  LINE_W  fill data
REQ-005 The block SHALL have these dcache ports:
- dc_req_valid  in  1  dcache request
- dc_req_ready  out  1  request accepted this cycle
- dc_req_addr  in  MEM_ADDR_W  line address
- dc_req_we  in  1  1 = write-back, 0 = fill
- dc_req_wdata  in  LINE_W  write-back line
- dc_rsp_valid  out  1  fill data valid, one-cycle pulse, reads only
- dc_rsp_data  out  LINE_W  fill data
REQ-006 The block SHALL have these memory-side ports:
- mem_req_valid  out  1  request to backing memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  MEM_ADDR_W  line address
- mem_req_we  out  1  write enable
- mem_req_wdata  out  LINE_W  write line
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  LINE_W  read data
REQ-007 The block SHALL have output conflict_cnt, 32 bits: the number of cycles in ARB_IDLE with both requests valid.

Function
REQ-008 The block SHALL implement the FSM states ARB_IDLE, ARB_ISSUE and ARB_WAIT, with exactly one memory transaction outstanding.
REQ-009 In ARB_IDLE, the block SHALL assert at most one of ic_req_ready/dc_req_ready, combinationally, to the winner among the valid requesters; outside ARB_IDLE both readies SHALL be 0.
REQ-010 Arbitration SHALL be round-robin: on a tie, grant the requester not in last_grant; with a single valid requester, grant it; last_grant updates on every accepted handshake.
REQ-011 On a handshake, the block SHALL register owner, addr, we (0 for icache) and wdata, then go to ARB_ISSUE.
REQ-012 In ARB_ISSUE, mem_req_valid SHALL be 1 with the registered fields stable until mem_req_ready; then:
- we=1: go to ARB_IDLE with no response.
- we=0: go to ARB_WAIT.
REQ-013 In ARB_WAIT, when mem_rsp_valid=1, the block SHALL:
- register mem_rsp_data into the owner's rsp_data;
- pulse the owner's rsp_valid in the next cycle;
- enter ARB_IDLE.
The next grant SHALL be possible in that same cycle.
REQ-014 Minimum latency SHALL be:
- request handshake at cycle N -> mem_req_valid at N+1;
- mem_rsp_valid at M -> rsp_valid at M+1.
REQ-015 mem_rsp_valid outside ARB_WAIT SHALL be ignored and SHALL have no effect on state or outputs.
REQ-016 rsp_data SHALL hold its last value between responses.
REQ-017 conflict_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-018 A requester dropping valid before ready SHALL not be granted, and no state SHALL change.

Reset
REQ-019 Asserting rst in any state SHALL asynchronously force:
- state ARB_IDLE;
- all valid/ready outputs 0;
- rsp_data 0, registered fields 0;
- last_grant = dcache (first tie goes to icache);
- conflict_cnt 0.
REQ-020 A transaction in flight at reset SHALL be discarded; no response SHALL be delivered after reset release.

Structure
REQ-021 The arb_state_e enum (ARB_IDLE/ARB_ISSUE/ARB_WAIT) and the arb_owner_e enum (ARB_IC/ARB_DC) SHALL live in the shared ama_riscv_defines package.
REQ-022 The two-way round-robin picker SHALL be a sub-module, ama_riscv_rr_arb2, with inputs req[1:0] and last, and a one-hot grant output.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Lone ic read, addr 0x010: ic_req_ready same cycle; mem_req_valid next cycle, addr 0x010, we=0; memory returns 0xDEAD_BEEF-pattern line -> ic_rsp_valid one cycle later with that data, dc_rsp_valid stays 0.
- ic and dc valid together from reset, 3 back-to-back: grants IC, DC, IC; conflict_cnt ends at 3 (ties only).
- dc write-back, addr 0x3FFF, wdata all-ones, mem_req_ready held low 5 cycles: mem_req fields stable 6 cycles; return to IDLE with no rsp pulse.
- Spurious mem_rsp_valid in ARB_IDLE and ARB_ISSUE: no rsp_valid, state unchanged.
- rst asserted mid ARB_WAIT: outputs 0 immediately; a later mem_rsp_valid produces no rsp_valid.
- conflict_cnt preloaded (force) to 0xFFFFFFFF, one tie cycle -> reads 0.
